// File: rtl/tone_player.sv
// Square-wave tone generator: plays a fixed-length note at 256*freq clocks per
// period for each accepted divider code, then stays silent for a fixed gap.
module tone_player #(
  parameter int unsigned DUR_CYCLES = 3000000,
  parameter int unsigned GAP_CYCLES = 600000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] freq_i,
  output logic       spk_o,
  output logic       busy_o,
  output logic       note_done_o
);

  localparam int unsigned DW = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DUR_LAST = DW'(DUR_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  if (DUR_CYCLES < 1) begin : g_bad_dur
    $error("tone_player: DUR_CYCLES must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("tone_player: GAP_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e         state_q,   state_d;
  logic [7:0]     note_q,    note_d;
  logic [7:0]     div_cnt_q, div_cnt_d;
  logic [7:0]     phase_q,   phase_d;
  logic [DW-1:0]  dur_cnt_q, dur_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic           note_done;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    note_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (freq_i != 8'd0) begin
          state_d   = PLAY;
          note_d    = freq_i;
          div_cnt_d = 8'd0;
          phase_d   = 8'd0;
          dur_cnt_d = '0;
        end
      end

      PLAY: begin
        // One waveform step every note_q clocks; phase wraps naturally at 8 bits.
        if (div_cnt_q == note_q - 8'd1) begin
          div_cnt_d = 8'd0;
          phase_d   = phase_q + 8'd1;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end

        if (dur_cnt_q == DUR_LAST) begin
          note_done = 1'b1;
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          dur_cnt_d = dur_cnt_q + DW'(1);
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      note_q    <= 8'd0;
      div_cnt_q <= 8'd0;
      phase_q   <= 8'd0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign spk_o       = (state_q == PLAY) ? phase_q[7] : 1'b0;
  assign busy_o      = (state_q != IDLE);
  assign note_done_o = note_done;

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player: table of note requests with expected
// waveform timing, scoreboard queue, plus reset / retrigger / back-to-back cases.
module tb_tone_player;

  localparam int DUR   = 2048;
  localparam int GAP   = 16;
  localparam int LIMIT = DUR + GAP + 100;

  logic       clk;
  logic       nrst;
  logic [7:0] freq_i;
  logic       spk_o;
  logic       busy_o;
  logic       note_done_o;

  tone_player #(
    .DUR_CYCLES(DUR),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .freq_i     (freq_i),
    .spk_o      (spk_o),
    .busy_o     (busy_o),
    .note_done_o(note_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle indices are PLAY-relative: k=0 is the first cycle after acceptance.
  typedef struct {
    logic [7:0] freq;
    int         rise;    // first spk_o rise, -1 if none
    int         fall;    // first fall after that rise, -1 if none
    int         period;  // second rise minus first rise, 0 if no second rise
    int         rises;   // rising edges within the note
    int         high;    // PLAY cycles with spk_o high
  } vec_t;

  vec_t vecs [6];
  vec_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive_req(input logic [7:0] f, input bit hold);
    @(negedge clk);
    freq_i = f;
    @(negedge clk);
    if (!hold) freq_i = 8'd0;
  endtask

  // Called at the negedge of PLAY cycle 0; returns at the first IDLE negedge.
  task automatic measure(input bit noise);
    vec_t e;
    int k, rise, fall, second, rises, high, dones, done_k, gap_hi, period;
    logic prev;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    k = 0; rise = -1; fall = -1; second = -1; rises = 0; high = 0;
    dones = 0; done_k = -1; gap_hi = 0; prev = 1'b0;
    while (busy_o && k < LIMIT) begin
      if (noise) begin
        if (k == 100)           freq_i = 8'd9;
        else if (k == 1500)     freq_i = 8'd0;
        else if (k == DUR + 5)  freq_i = 8'd9;
        else if (k == DUR + 6)  freq_i = 8'd0;
      end
      if (spk_o && !prev) begin
        rises++;
        if (rise < 0) rise = k;
        else if (second < 0) second = k;
      end
      if (!spk_o && prev && fall < 0) fall = k;
      if (spk_o) begin
        if (k < DUR) high++;
        else gap_hi++;
      end
      if (note_done_o) begin
        dones++;
        done_k = k;
      end
      prev = spk_o;
      @(negedge clk);
      k++;
    end
    period = (rise >= 0 && second >= 0) ? second - rise : 0;
    check($sformatf("f%0d_first_rise", e.freq), rise, e.rise);
    check($sformatf("f%0d_first_fall", e.freq), fall, e.fall);
    check($sformatf("f%0d_period", e.freq), period, e.period);
    check($sformatf("f%0d_rises", e.freq), rises, e.rises);
    check($sformatf("f%0d_high_cycles", e.freq), high, e.high);
    check($sformatf("f%0d_done_pulses", e.freq), dones, 1);
    check($sformatf("f%0d_done_cycle", e.freq), done_k, DUR - 1);
    check($sformatf("f%0d_busy_len", e.freq), k, DUR + GAP);
    check($sformatf("f%0d_spk_in_gap", e.freq), gap_hi, 0);
  endtask

  initial begin
    vecs[0] = '{freq: 8'd4,   rise: 512,  fall: 1024, period: 1024, rises: 2, high: 1024};
    vecs[1] = '{freq: 8'd1,   rise: 128,  fall: 256,  period: 256,  rises: 8, high: 1024};
    vecs[2] = '{freq: 8'd2,   rise: 256,  fall: 512,  period: 512,  rises: 4, high: 1024};
    vecs[3] = '{freq: 8'd3,   rise: 384,  fall: 768,  period: 768,  rises: 3, high: 896};
    vecs[4] = '{freq: 8'd8,   rise: 1024, fall: 2048, period: 0,    rises: 1, high: 1024};
    vecs[5] = '{freq: 8'd255, rise: -1,   fall: -1,   period: 0,    rises: 0, high: 0};

    // Reset held with a pending request: nothing may start.
    nrst   = 1'b0;
    freq_i = 8'd107;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_spk", spk_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", note_done_o, 0);
    end
    nrst = 1'b1;
    @(negedge clk);
    check("accept_after_release", busy_o, 1);
    nrst   = 1'b0;
    freq_i = 8'd0;
    @(negedge clk);
    check("abort_busy", busy_o, 0);
    nrst = 1'b1;

    // Table of single-pulse requests.
    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      drive_req(vecs[i].freq, 1'b0);
      measure(1'b0);
    end

    // freq_i changes mid-PLAY and pulses during GAP: note is unaffected.
    sb.push_back(vecs[0]);
    drive_req(8'd4, 1'b0);
    measure(1'b1);
    @(negedge clk);
    check("no_retrigger_idle", busy_o, 0);

    // Constant request: back-to-back notes with one idle-accept cycle between.
    sb.push_back(vecs[2]);
    drive_req(8'd2, 1'b1);
    measure(1'b0);
    for (int n = 0; n < 2; n++) begin
      check($sformatf("hold_idle_cycle%0d", n), busy_o, 0);
      sb.push_back(vecs[2]);
      @(negedge clk);
      check($sformatf("hold_reaccept%0d", n), busy_o, 1);
      measure(1'b0);
    end
    freq_i = 8'd0;
    @(negedge clk);
    check("hold_release_idle", busy_o, 0);

    // Reset at PLAY cycle 700 with spk_o high, then a clean restart.
    begin
      int dones;
      int hi_at_700;
      dones = 0;
      drive_req(8'd1, 1'b0);
      for (int k = 0; k < 700; k++) begin
        if (note_done_o) dones++;
        @(negedge clk);
      end
      hi_at_700 = int'(spk_o);
      check("pre_reset_spk_high", hi_at_700, 1);
      nrst = 1'b0;
      @(negedge clk);
      check("midplay_rst_spk", spk_o, 0);
      check("midplay_rst_busy", busy_o, 0);
      check("midplay_rst_done", note_done_o, 0);
      check("midplay_no_done", dones, 0);
      nrst = 1'b1;
    end
    sb.push_back(vecs[1]);
    drive_req(8'd1, 1'b0);
    measure(1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
